// File: rtl/priority_encoder_if.sv
// Request/grant bundle for priority_encoder.
// master drives requests and ready; slave presents the grant.
interface priority_encoder_if;
  logic [3:0] din;
  logic       en;
  logic       ready;
  logic [1:0] dout;
  logic       valid;
  logic [3:0] pend;
  logic       dup;

  modport master (
    output din,
    output en,
    output ready,
    input  dout,
    input  valid,
    input  pend,
    input  dup
  );

  modport slave (
    input  din,
    input  en,
    input  ready,
    output dout,
    output valid,
    output pend,
    output dup
  );
endinterface

// File: rtl/priority_encoder.sv
// 4-request pending-bit priority encoder with valid/ready grant.
// Define ROUND_ROBIN_EN for rotating selection; default is fixed priority.
module priority_encoder (
  input  logic               clk,
  input  logic               rst,
  priority_encoder_if.slave  bus
);

  logic [3:0] pend_q, pend_d;
  logic       dup_q, dup_d;
  logic [3:0] set_v, clr_v;
  logic [1:0] sel;
  logic       valid_w, hs;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] r;
    unique casez (v)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign valid_w = |pend_q;

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] dbl;
  logic [3:0] rot;

  // Rotate pend so the pointer bit lands at index 0.
  always_comb begin
    dbl = {pend_q, pend_q};
    rot = dbl[ptr_q +: 4];
    sel = ptr_q + lowest(rot);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs)
      ptr_d = bus.dout + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= 2'b00;
    else
      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel = lowest(pend_q);
  end
`endif

  assign hs    = valid_w & bus.ready;
  assign clr_v = hs ? (4'b0001 << bus.dout) : 4'b0000;
  assign set_v = bus.en ? 4'b0000 : bus.din;

  // Set is applied after clear so a same-edge set keeps the bit.
  always_comb begin
    pend_d = (pend_q & ~clr_v) | set_v;
    dup_d  = |(set_v & pend_q & ~clr_v);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 4'b0000;
      dup_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      dup_q  <= dup_d;
    end
  end

  assign bus.valid = valid_w;
  assign bus.dout  = valid_w ? sel : 2'b00;
  assign bus.pend  = pend_q;
  assign bus.dup   = dup_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Directed bench for priority_encoder with a queue-based scoreboard.
// Expectations adapt to ROUND_ROBIN_EN where selection differs.
module tb_priority_encoder;

`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;

  typedef struct {
    int         at;
    logic [3:0] pend;
    logic       valid;
    logic [1:0] dout;
    logic       dup;
  } exp_t;

  exp_t q[$];

  priority_encoder_if pif ();

  priority_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int at, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge%0d: got %0d want %0d", nm, at, act, exp);
    end
  endtask

  // Monitor: compare every output the DUT presents against queued expectations.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.at < cyc) begin
        chk("missed", e.at, cyc, e.at);
      end else begin
        chk("pend",  e.at, int'(pif.pend),  int'(e.pend));
        chk("valid", e.at, int'(pif.valid), int'(e.valid));
        chk("dout",  e.at, int'(pif.dout),  int'(e.dout));
        chk("dup",   e.at, int'(pif.dup),   int'(e.dup));
      end
    end
  end

  task automatic step(
    input logic       r,
    input logic [3:0] di,
    input logic       e,
    input logic       rd,
    input logic [3:0] ep,
    input logic       ev,
    input logic [1:0] ed,
    input logic       edp
  );
    exp_t x;
    rst       = r;
    pif.din   = di;
    pif.en    = e;
    pif.ready = rd;
    x.at    = cyc + 1;
    x.pend  = ep;
    x.valid = ev;
    x.dout  = ed;
    x.dup   = edp;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst din     en rdy  pend    v  dout  dup
    step(1, 4'b1111, 0, 1, 4'b0000, 0, 2'd0, 0);
    step(0, 4'b0110, 0, 0, 4'b0110, 1, 2'd1, 0);
    step(0, 4'b0000, 1, 1, 4'b0100, 1, 2'd2, 0);
    step(0, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 0);
    step(0, 4'b1111, 1, 1, 4'b0000, 0, 2'd0, 0);
    step(1, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0);
    // duplicate request detection and set-wins
    step(0, 4'b0001, 0, 0, 4'b0001, 1, 2'd0, 0);
    step(0, 4'b0001, 0, 0, 4'b0001, 1, 2'd0, 1);
    step(0, 4'b0000, 0, 0, 4'b0001, 1, 2'd0, 0);
    step(0, 4'b0001, 1, 0, 4'b0001, 1, 2'd0, 0);
    step(0, 4'b0001, 0, 1, 4'b0001, 1, 2'd0, 0);
    step(0, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 0);
    step(1, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0);
    // drain all four requests
    step(0, 4'b1111, 0, 0, 4'b1111, 1, 2'd0, 0);
    step(0, 4'b0100, 0, 1, 4'b1110, 1, 2'd1, 1);
    step(0, 4'b0000, 1, 1, 4'b1100, 1, 2'd2, 0);
    step(0, 4'b0000, 1, 1, 4'b1000, 1, 2'd3, 0);
    step(0, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 0);
    // pointer wrap and pointer-dependent selection
    step(0, 4'b1001, 0, 0, 4'b1001, 1, 2'd0, 0);
    step(0, 4'b0000, 1, 1, 4'b1000, 1, 2'd3, 0);
    step(0, 4'b0001, 0, 0, 4'b1001, 1, RR ? 2'd3 : 2'd0, 0);
    step(0, 4'b0000, 0, 0, 4'b1001, 1, RR ? 2'd3 : 2'd0, 0);
    step(1, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0);
    // reset mid-sequence
    step(0, 4'b1010, 0, 0, 4'b1010, 1, 2'd1, 0);
    step(0, 4'b0000, 1, 1, 4'b1000, 1, 2'd3, 0);
    step(0, 4'b0010, 0, 0, 4'b1010, 1, RR ? 2'd3 : 2'd1, 0);
    step(1, 4'b0101, 0, 1, 4'b0000, 0, 2'd0, 0);
    step(0, 4'b1001, 0, 0, 4'b1001, 1, 2'd0, 0);
    step(0, 4'b0000, 1, 0, 4'b1001, 1, 2'd0, 0);
    @(negedge clk);
    #1;
    chk("drain", cyc, q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_encoder.md
PRIORITY_ENCODER -- requirements
Module: priority_encoder

Interface
REQ-001 The block SHALL have no parameters; request width is fixed at 4, code width at 2.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port din  input  4  request lines; bit i high = request for code i, multi-hot allowed.
REQ-005 Port en  input  1  active-low enable; high blocks capture of din.
REQ-006 Port dout  output  2  binary code of the selected pending request.
REQ-007 Port valid  output  1  high when dout holds a pending request.
REQ-008 Port ready  input  1  consumer accepts dout when valid and ready are both high at a rising edge.
REQ-009 Port pend  output  4  current pending-request register.
REQ-010 Port dup  output  1  one-cycle pulse: a request hit an already-pending bit.

Function
REQ-011 Each rising edge with en low SHALL OR din into pend; with en high din SHALL be ignored and pend SHALL be held, except for the clear in REQ-014.
REQ-012 valid SHALL be combinational from pend: high when pend is non-zero.
REQ-013 dout SHALL be combinational from pend and the selection rule in REQ-022 or REQ-023; dout SHALL be 2'b00 when valid is low.
REQ-014 A handshake (valid and ready high at an edge) SHALL clear bit dout of pend at that edge.
REQ-015 Latency: a request captured at edge N SHALL be visible on valid and dout in the cycle after edge N, with no added delay.
REQ-016 When a set and a clear of the same bit occur at one edge, the set SHALL win and the bit SHALL stay pending.
REQ-017 dup SHALL be registered and SHALL be high for the cycle after an edge where en was low and din[i] and pend[i] were both high and bit i was not cleared by a handshake at that edge.
REQ-018 With valid low, ready SHALL have no effect.
REQ-019 dout and valid SHALL stay stable while valid is high and ready is low, unless a higher-priority bit becomes pending.
REQ-020 A 4'b0000 request SHALL leave pend unchanged and SHALL NOT pulse dup.

Reset
REQ-021 With rst high at an edge, pend SHALL become 4'b0000, dup SHALL become 0 and the round-robin pointer SHALL become 2'b00; rst SHALL take precedence over din, en and ready. As a result valid SHALL be 0 and dout SHALL be 2'b00 in the cycle after reset.

Configuration
REQ-022 Without ROUND_ROBIN_EN, selection SHALL be fixed priority: the lowest-index pending bit wins (bit 0 highest).
REQ-023 With ROUND_ROBIN_EN defined, a 2-bit pointer SHALL be added:
- Selection SHALL scan pend starting at the pointer and wrap 3->0.
- On each handshake the pointer SHALL become dout+1 modulo 4.
- With no handshake the pointer SHALL be held.

Verification
REQ-024 Reset, then din=4'b0110 with en low for one cycle -> pend=0110, valid=1, dout=2'b01. Then ready=1 for one cycle -> pend=0100, dout=2'b10. Then one more cycle -> valid=0.
REQ-025 en high with din=4'b1111 -> pend stays 0000, valid=0, dup=0.
REQ-026 pend=0001 with din=4'b0001 and ready low -> dup=1 for exactly one cycle. With ready high at the same edge -> dup=0 and pend stays 0001 (set wins).
REQ-027 ROUND_ROBIN_EN defined, din=4'b1111 once, ready held high -> dout sequence 00,01,10,11, then valid=0. Without the macro, the same stimulus -> the same sequence 00,01,10,11.
REQ-028 ROUND_ROBIN_EN defined, after dout=11 is accepted, din=4'b1001 -> dout=00 (pointer wrapped). Without the macro, dout=00. With pointer=01 and pend=1001 -> dout=11 under the macro and 00 without it.
REQ-029 rst asserted mid-sequence with pend=1010 and ready=1 -> next cycle pend=0000, valid=0, dup=0, pointer=00.
